// File: rtl/vending_pkg.sv
// Shared definitions for the parametrised vending machine.
//   state_t  : FSM state encoding, which is also visible on the debug ports
//   COIN_*   : 2-bit coin codes delivered by the coin-acceptor front end
package vending_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_VEND    = 2'd2,
    ST_CHANGE  = 2'd3
  } state_t;

  localparam logic [1:0] COIN_NONE = 2'b00;
  localparam logic [1:0] COIN_A    = 2'b01;
  localparam logic [1:0] COIN_B    = 2'b10;
  localparam logic [1:0] COIN_C    = 2'b11;

endpackage

// File: rtl/vending_coin_decode.sv
// Combinational coin code to coin value translation.
// Ports:
//   coin  : 2-bit coin code (00 = no coin)
//   value : value of the coin in coin units, 0 when no coin is present
module vending_coin_decode #(
  parameter int unsigned CREDIT_W   = 6,
  parameter int unsigned COIN_A_VAL = 5,
  parameter int unsigned COIN_B_VAL = 10,
  parameter int unsigned COIN_C_VAL = 25
) (
  input  logic [1:0]          coin,
  output logic [CREDIT_W-1:0] value
);
  import vending_pkg::*;

  always_comb begin
    value = '0;
    case (coin)
      COIN_A:  value = CREDIT_W'(COIN_A_VAL);
      COIN_B:  value = CREDIT_W'(COIN_B_VAL);
      COIN_C:  value = CREDIT_W'(COIN_C_VAL);
      default: value = '0;
    endcase
  end

endmodule

// File: rtl/vending_machine_param.sv
// Parametrised coin vending FSM with credit accumulator, cancel/refund and
// change return over a valid/ack handshake.
// Build option: define VENDING_MULTI_VEND_EN to keep vending while the
// remaining credit still covers the price; otherwise one vend per purchase.
// Ports:
//   clk          : system clock, rising edge
//   reset        : asynchronous active-high reset
//   coin         : coin code sampled every edge, 00 = no coin
//   cancel       : level request to refund current credit
//   change_ack   : change actuator accepted the offered change
//   out          : dispense pulse, high for each vend cycle
//   change       : change amount, non-zero only while change_valid
//   change_valid : change offered, held until change_ack
//   coin_reject  : one-cycle pulse after a coin that was returned
//   credit       : current accumulated credit
//   state        : current FSM state
//   newstate     : combinational next state
module vending_machine_param #(
  parameter int unsigned CREDIT_W   = 6,
  parameter int unsigned PRICE      = 15,
  parameter int unsigned COIN_A_VAL = 5,
  parameter int unsigned COIN_B_VAL = 10,
  parameter int unsigned COIN_C_VAL = 25
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [1:0]          coin,
  input  logic                cancel,
  input  logic                change_ack,
  output logic                out,
  output logic [CREDIT_W-1:0] change,
  output logic                change_valid,
  output logic                coin_reject,
  output logic [CREDIT_W-1:0] credit,
  output logic [1:0]          state,
  output logic [1:0]          newstate
);
  import vending_pkg::*;

  localparam logic [CREDIT_W:0]   PRICE_EXT = (CREDIT_W+1)'(PRICE);
  localparam logic [CREDIT_W-1:0] PRICE_C   = CREDIT_W'(PRICE);

  state_t              state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic                reject_q, reject_d;
  logic [CREDIT_W-1:0] coin_val;
  logic [CREDIT_W:0]   sum;
  logic [CREDIT_W-1:0] remainder;
  logic                coin_ok;

  vending_coin_decode #(
    .CREDIT_W  (CREDIT_W),
    .COIN_A_VAL(COIN_A_VAL),
    .COIN_B_VAL(COIN_B_VAL),
    .COIN_C_VAL(COIN_C_VAL)
  ) u_decode (
    .coin (coin),
    .value(coin_val)
  );

  // One extra bit so a coin that would overflow the credit register is
  // detected and rejected instead of wrapping.
  assign sum       = {1'b0, credit_q} + {1'b0, coin_val};
  assign remainder = credit_q - PRICE_C;

  // cancel wins over a coin in the same cycle, so the coin is handed back.
  assign coin_ok = (coin != COIN_NONE) && !cancel && !sum[CREDIT_W] &&
                   ((state_q == ST_IDLE) || (state_q == ST_COLLECT));

  always_comb begin
    state_d  = state_q;
    credit_d = credit_q;
    reject_d = (coin != COIN_NONE) && !coin_ok;
    case (state_q)
      ST_IDLE: begin
        if (coin_ok) begin
          credit_d = sum[CREDIT_W-1:0];
          state_d  = (sum >= PRICE_EXT) ? ST_VEND : ST_COLLECT;
        end
      end
      ST_COLLECT: begin
        if (cancel) begin
          state_d = ST_CHANGE;
        end else if (coin_ok) begin
          credit_d = sum[CREDIT_W-1:0];
          state_d  = (sum >= PRICE_EXT) ? ST_VEND : ST_COLLECT;
        end
      end
      ST_VEND: begin
        credit_d = remainder;
`ifdef VENDING_MULTI_VEND_EN
        if (remainder >= PRICE_C) begin
          state_d = ST_VEND;
        end else if (remainder != '0) begin
          state_d = ST_CHANGE;
        end else begin
          state_d = ST_IDLE;
        end
`else
        if (remainder != '0) begin
          state_d = ST_CHANGE;
        end else begin
          state_d = ST_IDLE;
        end
`endif
      end
      ST_CHANGE: begin
        if (change_ack) begin
          credit_d = '0;
          state_d  = ST_IDLE;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        credit_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      credit_q <= '0;
      reject_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      credit_q <= credit_d;
      reject_q <= reject_d;
    end
  end

  assign out          = (state_q == ST_VEND);
  assign change_valid = (state_q == ST_CHANGE);
  assign change       = (state_q == ST_CHANGE) ? credit_q : '0;
  assign coin_reject  = reject_q;
  assign credit       = credit_q;
  assign state        = state_q;
  assign newstate     = state_d;

endmodule

// File: tb/tb_vending_machine_param.sv
// Self-checking bench for vending_machine_param (default parameters).
// A purchase-level model tracks credit and machine phase as integers and is
// compared against every DUT output on each falling clock edge; directed
// scenarios add literal expectations, then randomized coins/cancel/ack run.
module tb_vending_machine_param;

  localparam int CW    = 6;
  localparam int PRICE = 15;
  localparam int MAXC  = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [1:0]    coin = 2'b00;
  logic          cancel = 1'b0;
  logic          change_ack = 1'b0;
  logic          out;
  logic [CW-1:0] change;
  logic          change_valid;
  logic          coin_reject;
  logic [CW-1:0] credit;
  logic [1:0]    state;
  logic [1:0]    newstate;

  int checks = 0;
  int errors = 0;

  // model: phase 0 idle, 1 collecting, 2 vending, 3 returning change
  int m_phase = 0;
  int m_credit = 0;
  int m_rej = 0;

  vending_machine_param dut (
    .clk         (clk),
    .reset       (reset),
    .coin        (coin),
    .cancel      (cancel),
    .change_ack  (change_ack),
    .out         (out),
    .change      (change),
    .change_valid(change_valid),
    .coin_reject (coin_reject),
    .credit      (credit),
    .state       (state),
    .newstate    (newstate)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int coin_value(input int c);
    case (c)
      1:       return 5;
      2:       return 10;
      3:       return 25;
      default: return 0;
    endcase
  endfunction

  // Purchase rules: what happens to phase/credit for one sampled input set.
  function automatic void model_next(input int ph, input int cr, input int c,
                                     input int can, input int ack,
                                     output int nph, output int ncr,
                                     output int rej);
    int  sum;
    bit  takes;
    sum   = cr + coin_value(c);
    takes = (c != 0) && (ph <= 1) && (can == 0) && (sum <= MAXC);
    nph   = ph;
    ncr   = cr;
    rej   = (c != 0 && !takes) ? 1 : 0;
    if (ph == 1 && can != 0) begin
      nph = 3;
    end else if (takes) begin
      ncr = sum;
      nph = (sum >= PRICE) ? 2 : 1;
    end else if (ph == 2) begin
      ncr = cr - PRICE;
`ifdef VENDING_MULTI_VEND_EN
      if (ncr >= PRICE) nph = 2;
      else nph = (ncr > 0) ? 3 : 0;
`else
      nph = (ncr > 0) ? 3 : 0;
`endif
    end else if (ph == 3 && ack != 0) begin
      ncr = 0;
      nph = 0;
    end
  endfunction

  always @(posedge clk or posedge reset) begin
    int nph, ncr, rej;
    if (reset) begin
      m_phase  = 0;
      m_credit = 0;
      m_rej    = 0;
    end else begin
      model_next(m_phase, m_credit, int'(coin), int'(cancel), int'(change_ack),
                 nph, ncr, rej);
      m_phase  = nph;
      m_credit = ncr;
      m_rej    = rej;
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    int nph, ncr, rej;
    model_next(m_phase, m_credit, int'(coin), int'(cancel), int'(change_ack),
               nph, ncr, rej);
    chk("state",        int'(state),        m_phase);
    chk("newstate",     int'(newstate),     nph);
    chk("credit",       int'(credit),       m_credit);
    chk("out",          int'(out),          (m_phase == 2) ? 1 : 0);
    chk("change_valid", int'(change_valid), (m_phase == 3) ? 1 : 0);
    chk("change",       int'(change),       (m_phase == 3) ? m_credit : 0);
    chk("coin_reject",  int'(coin_reject),  m_rej);
  end

  // Apply inputs, let one rising edge pass, settle 2 time units.
  task automatic tick(input logic [1:0] c, input logic can, input logic ack);
    coin       = c;
    cancel     = can;
    change_ack = ack;
    @(posedge clk);
    #2;
  endtask

  initial begin
    #1 reset = 1'b1;
    #2;
    chk("rst_state",  int'(state), 0);
    chk("rst_credit", int'(credit), 0);
    chk("rst_out",    int'(out), 0);
    chk("rst_cv",     int'(change_valid), 0);
    chk("rst_rej",    int'(coin_reject), 0);
    #9 reset = 1'b0;

    // 1: three A coins make exactly the price
    tick(2'b01, 0, 0); chk("s1_credit5", int'(credit), 5);
    tick(2'b01, 0, 0); chk("s1_credit10", int'(credit), 10);
    tick(2'b01, 0, 0); chk("s1_credit15", int'(credit), 15);
    chk("s1_out", int'(out), 1);
    tick(2'b00, 0, 0);
    chk("s1_out_end", int'(out), 0);
    chk("s1_cv", int'(change_valid), 0);
    chk("s1_idle", int'(state), 0);
    chk("s1_credit0", int'(credit), 0);

    // 2: overpay by 5, change held without ack
    tick(2'b10, 0, 0);
    tick(2'b10, 0, 0); chk("s2_credit20", int'(credit), 20);
    chk("s2_out", int'(out), 1);
    for (int i = 0; i < 3; i++) begin
      tick(2'b00, 0, 0);
      chk("s2_cv_hold", int'(change_valid), 1);
      chk("s2_change5", int'(change), 5);
    end
    tick(2'b00, 0, 1);
    chk("s2_idle", int'(state), 0);
    chk("s2_credit0", int'(credit), 0);
    chk("s2_change0", int'(change), 0);

    // 3: cancel with a simultaneous coin
    tick(2'b01, 0, 0);
    tick(2'b10, 1, 0);
    chk("s3_reject", int'(coin_reject), 1);
    chk("s3_change", int'(change), 5);
    chk("s3_state", int'(state), 3);
    chk("s3_out", int'(out), 0);
    tick(2'b00, 0, 1);
    chk("s3_reject_end", int'(coin_reject), 0);

    // 4: single C coin, coin during change is rejected
    tick(2'b11, 0, 0); chk("s4_vend", int'(out), 1);
    tick(2'b00, 0, 0); chk("s4_change10", int'(change), 10);
    tick(2'b01, 0, 0);
    chk("s4_reject", int'(coin_reject), 1);
    chk("s4_change_kept", int'(change), 10);
    tick(2'b00, 0, 1);

    // 5: asynchronous reset in the middle of a vend
    tick(2'b10, 0, 0);
    tick(2'b01, 0, 0);
    chk("s5_vend", int'(out), 1);
    #1 reset = 1'b1;
    #1;
    chk("s5_state", int'(state), 0);
    chk("s5_credit", int'(credit), 0);
    chk("s5_out", int'(out), 0);
    coin = 2'b00;
    @(negedge clk);
    #1 reset = 1'b0;

    // 6: credit 35 covers two prices only with multi-vend
    tick(2'b10, 0, 0);
    tick(2'b11, 0, 0);
    chk("s6_out1", int'(out), 1);
    chk("s6_credit35", int'(credit), 35);
    tick(2'b00, 0, 0);
`ifdef VENDING_MULTI_VEND_EN
    chk("s6_out2", int'(out), 1);
    tick(2'b00, 0, 0);
    chk("s6_change5", int'(change), 5);
`else
    chk("s6_out_single", int'(out), 0);
    chk("s6_change20", int'(change), 20);
`endif
    chk("s6_cv", int'(change_valid), 1);
    tick(2'b00, 0, 1);

    // randomized traffic against the model
    for (int i = 0; i < 500; i++) begin
      tick(2'($urandom_range(0, 3)), ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 2) == 0));
    end
    tick(2'b00, 0, 0);

    @(posedge clk);
    #2;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vending_machine_param.md
Name: vending_machine_param

Overview:
Parametrised successor to the fixed-price coin vending FSM. It has a configurable price, three coin denominations and a credit accumulator. It adds cancel/refund and change return through a valid/ack handshake, and rejects coins it cannot accept. It sits between the coin-acceptor front end and the dispense/change actuators, and exposes state and newstate for debug and the bench.

Parameters:
CREDIT_W, 6, width of credit, change and price arithmetic in coin units
PRICE, 15, product price; legal range 1..2^CREDIT_W-1
COIN_A_VAL, 5, value of coin code 2'b01
COIN_B_VAL, 10, value of coin code 2'b10
COIN_C_VAL, 25, value of coin code 2'b11

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous active-high reset
coin  input  2  coin code sampled every edge; 00 = no coin
cancel  input  1  level; request refund of current credit
change_ack  input  1  change actuator accepted change
out  output  1  dispense, one cycle per vend
change  output  CREDIT_W  change amount; valid only while change_valid
change_valid  output  1  change offered, held until ack
coin_reject  output  1  one-cycle pulse, coin returned to user
credit  output  CREDIT_W  current accumulated credit
state  output  2  current FSM state
newstate  output  2  combinational next state

Behaviour:
- State encoding: IDLE=0, COLLECT=1, VEND=2, CHANGE=3. The state register and credit register update on rising clk.
- Reset: asynchronous. Forces state=IDLE, credit=0, out=0, change_valid=0, change=0 and coin_reject=0 immediately. Credit held mid-operation is discarded.
- Moore outputs: out=(state==VEND), change_valid=(state==CHANGE), change=credit in CHANGE and 0 otherwise.
- coin_reject is registered: it is high for the cycle after a rejected coin sample.
- Coin value: v = COIN_x_VAL for the code; sum = credit+v, computed at CREDIT_W+1 bits.
- A coin is accepted only in IDLE or COLLECT, with no cancel, and when sum ≤ 2^CREDIT_W-1. Otherwise it is rejected: credit is unchanged and coin_reject pulses.
- IDLE:
  - accepted coin → credit=sum; next state VEND if sum ≥ PRICE, else COLLECT.
  - cancel alone is ignored.
- COLLECT:
  - cancel has priority over coin; the coin in the same cycle is rejected. Next state is CHANGE (credit > 0 is guaranteed here).
  - accepted coin → credit=sum; VEND if sum ≥ PRICE, else stay in COLLECT.
- VEND:
  - lasts exactly one cycle; on exit credit = credit - PRICE.
  - next state is CHANGE if the remainder > 0, else IDLE. Exception with MULTI_VEND_EN is described below.
  - coins are rejected; cancel is ignored.
- CHANGE:
  - change_valid and change are held stable until change_ack is sampled high.
  - on ack: credit=0, next state IDLE.
  - coins are rejected; cancel is ignored. change_ack outside CHANGE is ignored.
- Latency: coin sample at edge k → out high for cycle k..k+1. The earliest change_valid is the cycle after out.
- Arithmetic: unsigned throughout. credit never exceeds 2^CREDIT_W-1 and never underflows, because VEND is only entered with credit ≥ PRICE.
- newstate is the pure combinational next-state value; state equals the previous newstate.

Optional Feature:
VENDING_MULTI_VEND_EN.
- Defined: on VEND exit, if the remainder ≥ PRICE the FSM stays in VEND. out stays high and each cycle counts one vend; credit drops by PRICE per cycle until remainder < PRICE, then the FSM goes to CHANGE or IDLE.
- Undefined: exactly one vend per purchase; any remainder is returned as change.

Decomposition:
- Package vending_pkg holds:
  - the state encoding constants (ST_IDLE, ST_COLLECT, ST_VEND, ST_CHANGE)
  - the coin code constants (COIN_NONE, COIN_A, COIN_B, COIN_C)
- One sub-module, vending_coin_decode: combinational coin code → CREDIT_W-bit value, parametrised by the three COIN_x_VAL parameters.
- FSM, credit register and reject logic stay in the top module.

Test Plan:
All scenarios use default parameters.
1. Reset, then coin 01,01,01 on three consecutive edges:
   - credit steps 5, 10, 15.
   - out high for one cycle immediately after the third coin.
   - change_valid never asserts; state returns to IDLE with credit 0.
2. coin 10,10:
   - credit reaches 20; out pulses once.
   - change_valid=1 and change=5, held for 3 cycles with no ack.
   - change_ack=1 → next cycle IDLE, credit 0, change 0.
3. coin 01, then cancel and coin 10 in the same cycle:
   - coin_reject pulses; CHANGE with change=5; out never asserts.
4. coin 11 from IDLE:
   - VEND directly, then CHANGE with change=10.
   - coin 01 during CHANGE → coin_reject pulse, change stays 10.
5. coin 10 then coin 01 (credit 15), and reset raised mid-VEND before the clock edge:
   - state=IDLE, credit=0, out=0 with no clock edge needed.
6. With VENDING_MULTI_VEND_EN: coin 10 then coin 11 (credit 35):
   - out high for 2 consecutive cycles.
   - then CHANGE with change=5.
   - Without the macro: a single out pulse and change=20.
